// File: rtl/intr_ctl_if.sv
// Bus-side signal bundle for intr_ctl: address/write path, device lines, IRQ handshake.
interface intr_ctl_if #(
  parameter int unsigned NSRC  = 3,
  parameter int unsigned ABITS = 16,
  parameter int unsigned DBITS = 16
);
  logic [ABITS-1:0] abus;
  logic             re;
  logic [DBITS-1:0] wbus;
  logic             we;
  logic [NSRC-1:0]  src;
  logic             iack;
  logic             reti;
  logic             irq;
  logic [2:0]       iid;

  modport master (
    output abus, re, wbus, we, src, iack, reti,
    input  irq, iid
  );

  modport slave (
    input  abus, re, wbus, we, src, iack, reti,
    output irq, iid
  );
endinterface

// File: rtl/intr_ctl.sv
// Memory-mapped interrupt controller: pending/enable registers, fixed priority, IRQ/IACK/EOI FSM.
// Define INTR_CTL_EDGE_EN for rising-edge capture with W1C/IACK clears; default is level mode.
module intr_ctl #(
  parameter int unsigned     NSRC  = 3,
  parameter int unsigned     ABITS = 16,
  parameter int unsigned     DBITS = 16,
  parameter logic [ABITS-1:0] PADDR = 16'hFFE8,
  parameter logic [ABITS-1:0] EADDR = 16'hFFEA,
  parameter logic [ABITS-1:0] SADDR = 16'hFFEC
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  intr_ctl_if.slave        bus,
  // Tri-state read bus is kept as a plain port so the bus can be shared with other devices.
  inout  wire  [DBITS-1:0] rbus_io
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StSvc  = 2'd2
  } state_e;

  state_e          state_q;
  logic            irq_q;
  logic [2:0]      iid_q;
  logic [NSRC-1:0] ipend_q, ipend_d;
  logic [NSRC-1:0] iena_q, iena_d;
  logic [NSRC-1:0] pend_en;
  logic [NSRC-1:0] sel;
  logic [2:0]      pick;
  logic            cur_live;
  logic            eoi;
  logic            hit_p, hit_e, hit_s;
  logic [DBITS-1:0] rdata;
  logic            unused_wbus;

  assign hit_p = (bus.abus == PADDR);
  assign hit_e = (bus.abus == EADDR);
  assign hit_s = (bus.abus == SADDR);

  assign sel      = NSRC'(1) << iid_q;
  assign pend_en  = ipend_q & iena_q;
  // Withdrawal looks at next-cycle values so a mask write drops the request on its own edge.
  assign cur_live = |(ipend_d & iena_d & sel);
  assign eoi      = bus.reti | (bus.we & hit_s);

  assign iena_d = (bus.we && hit_e) ? bus.wbus[NSRC-1:0] : iena_q;

`ifdef INTR_CTL_EDGE_EN
  logic [NSRC-1:0] hist_q;
  logic [NSRC-1:0] set_v, clr_v;
  logic            iack_take;

  assign iack_take = bus.iack & (state_q == StReq);
  assign set_v     = bus.src & ~hist_q;
  assign clr_v     = ((bus.we && hit_p) ? bus.wbus[NSRC-1:0] : '0) | (iack_take ? sel : '0);
  // Set wins over a same-cycle clear.
  assign ipend_d   = (ipend_q & ~clr_v) | set_v;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
    end else begin
      hist_q <= bus.src;
    end
  end
`else
  assign ipend_d = bus.src;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ipend_q <= '0;
      iena_q  <= '0;
    end else begin
      ipend_q <= ipend_d;
      iena_q  <= iena_d;
    end
  end

  always_comb begin
    pick = 3'd0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (pend_en[i]) pick = 3'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      irq_q   <= 1'b0;
      iid_q   <= 3'd0;
    end else begin
      case (state_q)
        StReq: begin
          if (bus.iack) begin
            state_q <= StSvc;
            irq_q   <= 1'b0;
          end else if (!cur_live) begin
            state_q <= StIdle;
            irq_q   <= 1'b0;
          end
        end
        StSvc: begin
          if (eoi) state_q <= StIdle;
        end
        default: begin
          // Unused encoding 3 falls here and behaves as idle.
          if (|pend_en) begin
            state_q <= StReq;
            irq_q   <= 1'b1;
            iid_q   <= pick;
          end
        end
      endcase
    end
  end

  assign bus.irq = irq_q;
  assign bus.iid = iid_q;

  always_comb begin
    rdata = '0;
    if (hit_p) begin
      rdata[NSRC-1:0] = ipend_q;
    end else if (hit_e) begin
      rdata[NSRC-1:0] = iena_q;
    end else if (hit_s) begin
      rdata[5:0] = {state_q, irq_q, iid_q};
    end
  end

  assign rbus_io = (bus.re && (hit_p || hit_e || hit_s)) ? rdata : {DBITS{1'bz}};

  assign unused_wbus = ^bus.wbus;

endmodule

// File: tb/tb_intr_ctl.sv
// Directed bench for intr_ctl; expectations branch on INTR_CTL_EDGE_EN where modes differ.
module tb_intr_ctl;

  logic clk;
  logic rst_n;
  wire [15:0] rbus;

  int n_checks = 0;
  int n_pass   = 0;

  intr_ctl_if #(.NSRC(3), .ABITS(16), .DBITS(16)) bus_if ();

  intr_ctl dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus_if.slave),
    .rbus_io (rbus)
  );

  // Undriven bus floats to all ones so a stray driver is visible.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pu
    pullup (rbus[gi]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef INTR_CTL_EDGE_EN
  localparam bit Edge = 1'b1;
`else
  localparam bit Edge = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    bus_if.abus = addr;
    bus_if.wbus = data;
    bus_if.we   = 1'b1;
    tick();
    bus_if.we   = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    bus_if.abus = addr;
    bus_if.re   = 1'b1;
    #1;
    d = rbus;
    bus_if.re   = 1'b0;
    check_val(tag, {16'h0, d}, {16'h0, exp});
  endtask

  task automatic check_out(input string tag, input logic irq_e, input logic [2:0] iid_e);
    check_val(tag, {28'h0, bus_if.irq, bus_if.iid}, {28'h0, irq_e, iid_e});
  endtask

  initial begin
    rst_n       = 1'b0;
    bus_if.abus = '0;
    bus_if.re   = 1'b0;
    bus_if.wbus = '0;
    bus_if.we   = 1'b0;
    bus_if.src  = '0;
    bus_if.iack = 1'b0;
    bus_if.reti = 1'b0;
    #1;
    check_out("rst_out", 1'b0, 3'd0);
    check_reg("rst_ipend", 16'hFFE8, 16'h0000);
    check_reg("rst_iena", 16'hFFEA, 16'h0000);
    check_reg("rst_istat", 16'hFFEC, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    tick();

    // Single source on line 2.
    bus_write(16'hFFEA, 16'h0004);
    check_reg("iena_wr", 16'hFFEA, 16'h0004);
    bus_if.src = 3'b100;
    tick();
    check_reg("single_pend", 16'hFFE8, 16'h0004);
    check_out("single_nolat", 1'b0, 3'd0);
    if (Edge) bus_if.src = 3'b000;
    tick();
    check_out("single_irq", 1'b1, 3'd2);
    check_reg("single_req_st", 16'hFFEC, 16'h001A);
    tick(2);
    check_out("single_hold", 1'b1, 3'd2);
    bus_if.iack = 1'b1;
    tick();
    bus_if.iack = 1'b0;
    check_out("single_ack", 1'b0, 3'd2);
    check_reg("single_svc_st", 16'hFFEC, 16'h0022);
    check_reg("single_ack_pend", 16'hFFE8, Edge ? 16'h0000 : 16'h0004);
    bus_if.src = 3'b000;
    bus_if.iack = 1'b1;
    tick();
    bus_if.iack = 1'b0;
    check_reg("svc_iack_ign", 16'hFFEC, 16'h0022);
    check_reg("svc_pend", 16'hFFE8, 16'h0000);
    bus_if.reti = 1'b1;
    tick();
    bus_if.reti = 1'b0;
    check_reg("reti_idle", 16'hFFEC, 16'h0002);

    // Priority between lines 1 and 2.
    bus_write(16'hFFEA, 16'h0007);
    bus_if.src = 3'b110;
    tick();
    check_reg("prio_pend", 16'hFFE8, 16'h0006);
    if (Edge) bus_if.src = 3'b000;
    tick();
    check_out("prio_iid1", 1'b1, 3'd1);
    bus_if.iack = 1'b1;
    tick();
    bus_if.iack = 1'b0;
    if (!Edge) bus_if.src = 3'b100;
    check_reg("prio_svc", 16'hFFEC, 16'h0021);
    tick();
    bus_write(16'hFFEC, 16'h0000);
    check_reg("eoi_wr_idle", 16'hFFEC, 16'h0001);
    tick();
    check_out("prio_iid2", 1'b1, 3'd2);
    // Higher-priority arrival during REQ must not change IID.
    bus_if.src = Edge ? 3'b001 : 3'b101;
    tick();
    check_out("no_rearb", 1'b1, 3'd2);
    check_reg("rearb_pend", 16'hFFE8, 16'h0005);
    if (Edge) bus_if.src = 3'b000;
    bus_if.iack = 1'b1;
    tick();
    bus_if.iack = 1'b0;
    if (!Edge) bus_if.src = 3'b001;
    check_reg("rearb_svc", 16'hFFEC, 16'h0022);
    bus_if.reti = 1'b1;
    tick();
    bus_if.reti = 1'b0;
    tick();
    check_reg("req_iid0", 16'hFFEC, 16'h0018);

    // Mask withdrawal while requesting source 0.
    bus_write(16'hFFEA, 16'h0006);
    check_out("mask_wd", 1'b0, 3'd0);
    check_reg("mask_wd_st", 16'hFFEC, 16'h0000);
    bus_if.iack = 1'b1;
    tick();
    bus_if.iack = 1'b0;
    check_reg("mask_no_ack", 16'hFFEC, 16'h0000);
    check_reg("mask_pend", 16'hFFE8, 16'h0001);

    // Set versus W1C on the same bit and edge.
    bus_if.src = 3'b001;
    bus_write(16'hFFE8, 16'h0001);
    check_reg("collide", 16'hFFE8, 16'h0001);
    bus_if.src = 3'b000;
    bus_write(16'hFFE8, 16'h0001);
    check_reg("w1c_clear", 16'hFFE8, 16'h0000);

    // Foreign addresses.
    check_reg("iso_read", 16'hFFF0, 16'hFFFF);
    bus_if.abus = 16'hFFEA;
    bus_if.re   = 1'b0;
    #1;
    check_val("iso_re0", {16'h0, rbus}, 32'h0000_FFFF);
    bus_write(16'hFFEE, 16'hFFFF);
    check_reg("iso_iena", 16'hFFEA, 16'h0006);
    check_reg("iso_pend", 16'hFFE8, 16'h0000);
    check_reg("iso_istat", 16'hFFEC, 16'h0000);

    // Reset asserted mid-REQ with two lines pending.
    bus_write(16'hFFEA, 16'h0007);
    bus_if.src = 3'b101;
    tick();
    check_reg("pre_rst_pend", 16'hFFE8, 16'h0005);
    if (Edge) bus_if.src = 3'b000;
    tick();
    check_out("pre_rst_req", 1'b1, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_rst_out", 1'b0, 3'd0);
    check_reg("mid_rst_pend", 16'hFFE8, 16'h0000);
    check_reg("mid_rst_iena", 16'hFFEA, 16'h0000);
    bus_if.src = 3'b000;
    rst_n = 1'b1;
    tick();
    check_reg("post_rst_st", 16'hFFEC, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intr_ctl.md
# intr_ctl

Memory-mapped interrupt controller on the processor's data bus, alongside the display, LED, key, switch and timer devices. It collects the device interrupt lines into pending bits, masks and prioritises them, and presents a single request plus source ID to the processor's interrupt entry logic. Through an IRQ/IACK/EOI handshake, at most one interrupt is in service at a time.

## Interface
- NSRC, 3: number of interrupt sources (1..8); bit 0 has the highest priority
- ABITS, 16: bus address width
- DBITS, 16: bus data width
- PADDR, 16'hFFE8: IPEND register address (read pending; write-1-to-clear)
- EADDR, 16'hFFEA: IENA register address (read/write enable mask)
- SADDR, 16'hFFEC: ISTAT register address (read status; any write = EOI)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RSTN  in  1  reset, asynchronous, active-low
- ABUS  in  ABITS  bus address, driven from the MEM stage ALU result
- RBUS  inout(tri)  DBITS  read data; driven only on a read hit, otherwise 'z
- RE  in  1  read enable
- WBUS  in  DBITS  write data
- WE  in  1  write enable
- SRC  in  NSRC  device interrupt lines, synchronous to CLK
- IACK  in  1  processor takes the current request (one-cycle pulse)
- RETI  in  1  processor executed RETI (one-cycle pulse); acts as EOI
- IRQ  out  1  interrupt request to the processor
- IID  out  3  index of the requested or in-service source

## Operation
Registers:
- IPEND[NSRC-1:0]: set by the source event; cleared by a W1C write to PADDR or by IACK for bit IID.
- IENA[NSRC-1:0]: written from WBUS[NSRC-1:0] at EADDR.
- ISTAT read value: {zeros, state[1:0] at bits 5:4, IRQ at bit 3, IID at bits 2:0}.

Reads:
- Combinational. When RE=1 and ABUS equals PADDR, EADDR or SADDR, RBUS carries the zero-extended register in the same cycle.
- For any other address, and for RE=0, RBUS is 'z.

State machine, 2-bit state:
- IDLE (0): if (IPEND & IENA) != 0, latch IID = lowest set index and go to REQ.
- REQ (1): IRQ = 1 and IID is held stable.
  - On IACK: clear IPEND[IID] and go to SVC.
  - Else, if IPEND[IID] & IENA[IID] = 0 (software cleared or masked it): go to IDLE with IRQ low.
- SVC (2): IRQ = 0 and IID holds the in-service source. EOI (RETI pulse, or WE at SADDR) returns to IDLE.
- State 3 is unreachable and decodes as IDLE.

Boundary rules:
- A set event and a clear (W1C or IACK) on the same bit in the same cycle: set wins.
- Multiple sources pending: lowest index wins. Re-arbitration happens only in IDLE; a higher-priority arrival during REQ does not change IID.
- IACK outside REQ, and EOI outside SVC, are ignored.
- W1C and IENA writes are honoured in every state.
- Reset assertion mid-operation (any state) forces, immediately: IPEND = 0, IENA = 0, state IDLE, IRQ = 0, IID = 0, edge history = 0.

## Timing
- All outputs come straight from registers; no combinational path from the inputs to IRQ or IID.
- SRC condition true at rising edge k: IPEND bit = 1 after edge k; IRQ = 1 after edge k+1 (2-cycle latency), provided the bit is enabled and the state is IDLE.
- IACK sampled at edge m: IRQ = 0 and IPEND[IID] = 0 after edge m.
- EOI at edge m: the next request can be raised after edge m+1.
- A write is committed at the edge where WE=1; a read in the following cycle returns the new value.

## Configuration
- INTR_CTL_EDGE_EN defined: a pending bit is set on the SRC rising edge (SRC=1 while the previous sample was 0), using an NSRC-bit history register. W1C clears work normally.
- INTR_CTL_EDGE_EN undefined: level mode.
  - IPEND is SRC registered each cycle; W1C writes and IACK clears have no effect.
  - Devices clear their own lines through their control registers.
  - The history register is not built.

## Test plan
- Reset: RSTN=0 mid-REQ with IPEND=3'b101 -> IRQ=0, IID=0 and IPEND=0 immediately; a read at FFE8 returns 16'h0000.
- Single source (edge mode): IENA=3'b100, SRC[2] pulses at edge 10 -> IPEND=3'b100 after edge 10; IRQ=1 and IID=2 after edge 11; IACK at edge 14 -> IRQ=0, ISTAT=16'h0022; RETI at edge 20 -> ISTAT=16'h0002 (IDLE).
- Priority: IENA=3'b111, SRC[1] and SRC[2] rise together -> IID=1; after IACK and EOI, IID=2 is raised 1 cycle after IDLE.
- Mask withdraw: in REQ with IID=0, write IENA=16'h0006 -> state IDLE, IRQ=0 after the write edge; no IACK is accepted afterwards.
- Collision: W1C write of 16'h0001 at FFE8 in the same cycle as a SRC[0] rising edge -> IPEND[0] stays 1.
- Bus isolation: RE=1 at ABUS=16'hFFF0 -> RBUS is 'z from this block; WE at 16'hFFEE -> no register changes.
